// File: rtl/cpu_ctrl_alu_core_if.sv
// Bus between the teaching-CPU core and its surroundings: opcode/operands in, strobes/result out.
interface cpu_ctrl_alu_core_if #(parameter int WIDTH = 8);
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clk_1s;
  logic             tick_1s;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src;
  logic             branch;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output op, a, b,
    input  clk_1s, tick_1s, reg_dst, reg_write, alu_src, branch,
           mem_read, mem_write, mem_to_reg, y, zero, carry, ovf
  );

  modport slave (
    input  op, a, b,
    output clk_1s, tick_1s, reg_dst, reg_write, alu_src, branch,
           mem_read, mem_write, mem_to_reg, y, zero, carry, ovf
  );
endinterface

// File: rtl/cpu_ctrl_alu_core.sv
// Clock divider, main control decoder and adder ALU of the 4-instruction teaching CPU.
// Optional ALU status flags are enabled by defining ALU_FLAGS_EN.
module cpu_ctrl_alu_core #(
  parameter int DIV_COUNT = 25_000_000,
  parameter int WIDTH     = 8
) (
  input  logic                 clk_50m,
  input  logic                 reset_n,
  cpu_ctrl_alu_core_if.slave   bus
);

  localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] counter;
  logic          clk_1s_q;
  logic          tick_q;

  // tick follows the new clk_1s value only on the wrap, so it marks rising edges alone
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      counter  <= '0;
      clk_1s_q <= 1'b0;
      tick_q   <= 1'b0;
    end else if (counter == LAST) begin
      counter  <= '0;
      clk_1s_q <= ~clk_1s_q;
      tick_q   <= ~clk_1s_q;
    end else begin
      counter  <= counter + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  assign bus.clk_1s  = clk_1s_q;
  assign bus.tick_1s = tick_q;

  logic [6:0] strobes;

  always_comb begin
    strobes = 7'b0000000;
    case (bus.op)
      2'b00:   strobes = 7'b1100000;
      2'b01:   strobes = 7'b0110101;
      2'b10:   strobes = 7'b0010010;
      2'b11:   strobes = 7'b0001000;
      default: strobes = 7'b0000000;
    endcase
  end

  assign {bus.reg_dst, bus.reg_write, bus.alu_src, bus.branch,
          bus.mem_read, bus.mem_write, bus.mem_to_reg} = strobes;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum;

  assign sum       = {1'b0, bus.a} + {1'b0, bus.b};
  assign bus.y     = sum[WIDTH-1:0];
  assign bus.zero  = (sum[WIDTH-1:0] == '0);
  assign bus.carry = sum[WIDTH];
  assign bus.ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.a[WIDTH-1]);
`else
  assign bus.y     = bus.a + bus.b;
  assign bus.zero  = 1'b0;
  assign bus.carry = 1'b0;
  assign bus.ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_alu_core.sv
// Directed scoreboard bench for cpu_ctrl_alu_core with DIV_COUNT=4.
// Flag expectations follow ALU_FLAGS_EN the same way the design does.
module tb_cpu_ctrl_alu_core;

  typedef struct {
    string      tag;
    logic [6:0] strobes;
    logic [7:0] y;
    logic [2:0] flags;
  } alu_exp_t;

  typedef struct {
    string tag;
    logic  clk_1s;
    logic  tick;
  } div_exp_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  alu_exp_t alu_q[$];
  div_exp_t div_q[$];

  cpu_ctrl_alu_core_if #(.WIDTH(8)) bus ();

  cpu_ctrl_alu_core #(.DIV_COUNT(4), .WIDTH(8)) dut (
    .clk_50m (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [6:0] exp_strobes,
                               input logic [7:0] exp_y, input logic [2:0] exp_flags);
    alu_exp_t e;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    e.tag     = tag;
    e.strobes = exp_strobes;
    e.y       = exp_y;
`ifdef ALU_FLAGS_EN
    e.flags   = exp_flags;
`else
    e.flags   = 3'b000;
`endif
    alu_q.push_back(e);
  endtask

  task automatic checkOutput();
    alu_exp_t e;
    #1;
    e = alu_q.pop_front();
    compare({e.tag, ".strobes"},
            {25'd0, bus.reg_dst, bus.reg_write, bus.alu_src, bus.branch,
             bus.mem_read, bus.mem_write, bus.mem_to_reg}, {25'd0, e.strobes});
    compare({e.tag, ".y"}, {24'd0, bus.y}, {24'd0, e.y});
    compare({e.tag, ".flags"}, {29'd0, bus.zero, bus.carry, bus.ovf}, {29'd0, e.flags});
  endtask

  // Pushes the expected divider outputs, optionally waits one clk_50m edge, then compares.
  task automatic divStep(input string tag, input bit wait_edge, input logic exp_clk, input logic exp_tick);
    div_exp_t e;
    e.tag    = tag;
    e.clk_1s = exp_clk;
    e.tick   = exp_tick;
    div_q.push_back(e);
    if (wait_edge) @(posedge clk);
    #1;
    e = div_q.pop_front();
    compare({e.tag, ".clk_1s"}, {31'd0, bus.clk_1s}, {31'd0, e.clk_1s});
    compare({e.tag, ".tick_1s"}, {31'd0, bus.tick_1s}, {31'd0, e.tick});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.op     = 2'b00;
    bus.a      = 8'h00;
    bus.b      = 8'h00;

    repeat (2) @(posedge clk);
    divStep("reset_state", 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      divStep($sformatf("div_edge%0d", n), 1'b1,
              ((n >= 4 && n < 8) || n >= 12) ? 1'b1 : 1'b0,
              (n == 4 || n == 12) ? 1'b1 : 1'b0);
    end

    // counter sits at 2 with clk_1s high: a short reset pulse must clear and restart phase
    #2;
    reset_n = 1'b0;
    divStep("midreset_async", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      divStep($sformatf("restart_edge%0d", n), 1'b1,
              (n == 4) ? 1'b1 : 1'b0, (n == 4) ? 1'b1 : 1'b0);
    end

    applyStimulus("op_add", 2'b00, 8'h12, 8'h34, 7'b1100000, 8'h46, 3'b000);
    checkOutput();
    applyStimulus("op_lw",  2'b01, 8'h05, 8'hFE, 7'b0110101, 8'h03, 3'b010);
    checkOutput();
    applyStimulus("op_sw",  2'b10, 8'hFF, 8'h01, 7'b0010010, 8'h00, 3'b110);
    checkOutput();
    applyStimulus("op_j",   2'b11, 8'h7F, 8'h01, 7'b0001000, 8'h80, 3'b001);
    checkOutput();
    applyStimulus("neg_ovf", 2'b00, 8'h80, 8'h80, 7'b1100000, 8'h00, 3'b111);
    checkOutput();

    reset_n = 1'b0;
    applyStimulus("decode_in_reset", 2'b01, 8'h20, 8'h22, 7'b0110101, 8'h42, 3'b000);
    checkOutput();
    reset_n = 1'b1;

    if (alu_q.size() != 0 || div_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain observed=%0d expected=0", alu_q.size() + div_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
